// File: rtl/rr_arbiter_8_pkg.sv
// rr_arbiter_8_pkg: shared constants, FSM states and slot-to-bit mapping for the round-robin arbiter
package rr_arbiter_8_pkg;
  localparam int N_REQ = 8;
  localparam int PTR_W = 3;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic logic [PTR_W-1:0] slot_to_bit(input logic [PTR_W-1:0] k);
    return PTR_W'(N_REQ - 1) - k;
  endfunction
endpackage

// File: rtl/rr_pick_8.sv
// rr_pick_8: combinational round-robin winner search over a double-width masked request vector
module rr_pick_8
  import rr_arbiter_8_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] win,
  output logic [PTR_W-1:0] idx,
  output logic             any
);
  logic [N_REQ-1:0]   s;
  logic [2*N_REQ-1:0] m;
  always_comb begin
    s = '0;
    for (int k = 0; k < N_REQ; k++) s[k] = req[slot_to_bit(PTR_W'(k))];
    m = {s, s} & ({(2*N_REQ){1'b1}} << ptr);
    idx = '0;
    any = 1'b0;
    for (int j = 2*N_REQ-1; j >= 0; j--) if (m[j]) begin idx = PTR_W'(j); any = 1'b1; end
    win = any ? N_REQ'(1) << slot_to_bit(idx) : '0;
  end
endmodule

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-requester round-robin arbiter with registered one-hot grant and valid/ready handshake
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter logic [PTR_W-1:0] RESET_PTR = 3'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             gnt_ready,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [PTR_W-1:0] ptr
);
  state_t           state, state_n;
  logic [PTR_W-1:0] cur, cur_n, ptr_n, pick_ptr, idx;
  logic [N_REQ-1:0] gnt_n, win;
  logic             any, hs, load;
  rr_pick_8 u_pick (.req(req), .ptr(pick_ptr), .win(win), .idx(idx), .any(any));
  always_comb begin
    hs = state == GRANT && gnt_ready;
    load = state == IDLE || hs;
    pick_ptr = state == GRANT ? cur + PTR_W'(1) : ptr;
    state_n = load ? (any ? GRANT : IDLE) : state;
    gnt_n = load ? win : gnt;
    cur_n = load && any ? idx : cur;
    ptr_n = hs ? cur + PTR_W'(1) : ptr;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      cur <= RESET_PTR;
      ptr <= RESET_PTR;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      cur <= cur_n;
      ptr <= ptr_n;
    end
  end
  assign gnt_valid = state == GRANT;
endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- Eight-requester round-robin arbiter with a registered one-hot grant and a valid/ready handshake.
- gnt[7:0] drives the din input of the downstream eight_to_three_encoder directly. The encoder's 3-bit code is the index of the winning requester.
- Mapping: slot k ↔ bit gnt[7-k]. The encoder turns gnt[7] into 3'b000 and gnt[0] into 3'b111, so slot k encodes to k.
- The grant is guaranteed one-hot whenever gnt_valid=1, so the encoder never sees an illegal input while the grant is qualified.

Parameters:
- RESET_PTR, 3'd0: slot that has highest priority after reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  8  request vector; req[7-k] is slot k's request; level-sensitive.
- gnt_ready  input  1  downstream accepts the current grant this cycle.
- gnt  output  8  registered one-hot grant; all zeros when gnt_valid=0.
- gnt_valid  output  1  gnt holds a valid grant.
- ptr  output  3  current highest-priority slot (debug/observability).

Behaviour:
- Reset (rst=1 at a rising edge), applied on that edge:
  - gnt=8'h00, gnt_valid=0, ptr=RESET_PTR, FSM=IDLE.
  - This takes priority over every other event, including a handshake in the same cycle.
- FSM states: IDLE, GRANT.
- Arbitration function (combinational), win(req, ptr):
  - Scan slots ptr, ptr+1, …, ptr+7, with wrap-around mod 8.
  - The first slot k whose request bit req[7-k]=1 wins.
  - If req=0, there is no winner.
- IDLE:
  - If req≠0, then on the next edge: gnt=onehot(7-k), gnt_valid=1, go to GRANT.
  - Request-to-grant latency is 1 cycle.
  - If req=0, stay in IDLE with gnt=0.
- GRANT, gnt_ready=0:
  - gnt and gnt_valid hold.
  - Changes to req, including the winner dropping its request, do not alter the grant.
- GRANT, gnt_ready=1 (handshake completes this edge):
  - ptr ← (k+1) mod 8, where k is the granted slot.
  - Re-arbitrate in the same cycle using the current req and the updated pointer, i.e. win(req, (k+1) mod 8).
  - Winner present: load the new gnt, stay in GRANT (back-to-back grants, no bubble).
  - No winner: gnt=0, gnt_valid=0, go to IDLE.
  - The same slot may win again only if it is the sole requester.
- ptr changes only on a completed handshake, never while idle or stalled.
- gnt_ready while gnt_valid=0 is ignored.
- Fairness: with all 8 requesting and gnt_ready tied high, each slot is granted exactly once per 8 consecutive grants.
- Invariants:
  - gnt_valid=0 ⇒ gnt=0.
  - gnt_valid=1 ⇒ gnt is exactly one-hot.
  - Both are assertion targets for the verification engineer.

Decomposition:
- Shared package: constant N_REQ=8, a ptr width of 3, the FSM state enum {IDLE, GRANT}, and a slot_to_bit function (7-k).
- Sub-module rr_pick_8 (combinational): inputs req and ptr, outputs a one-hot winner, winner index, and any flag.
  - Implement it as a double-width masked priority scan.
  - It is reused by the GRANT and IDLE paths.
- The top level holds the FSM, the grant register and the pointer.

Test Plan:
- Reset/idle:
  - Stimulus: rst=1 for 2 cycles, then release with req=0.
  - Required: gnt=8'h00, gnt_valid=0, ptr=0 throughout.
- Single request:
  - Stimulus: req=8'b0010_0000 (slot 2), gnt_ready=1.
  - Required: one cycle later gnt=8'b0010_0000 and gnt_valid=1; the encoder outputs 3'b010.
  - After acceptance: ptr=3; with req held, the next grant is slot 2 again.
- Full round-robin:
  - Stimulus: req=8'hFF, gnt_ready=1 continuously.
  - Required: grants are slot 0,1,…,7,0 on consecutive cycles, i.e. gnt=8'h80, 40, 20, 10, 08, 04, 02, 01, 80; no bubbles.
- Back-pressure:
  - Stimulus: req=8'hFF, gnt_ready=0 for 5 cycles, and drop req[7] during the stall.
  - Required: gnt stays 8'h80 with gnt_valid=1 and ptr stays 0.
  - When ready rises: accept, then gnt=8'h40, ptr=1.
- Wrap-around:
  - Stimulus: ptr=6 after prior grants; req=8'b1000_0010 (slots 0 and 6).
  - Required: slot 6 wins (gnt=8'h02), then slot 0 (gnt=8'h80), ptr=1.
- Reset mid-operation:
  - Stimulus: assert rst in the same cycle as a handshake, with gnt_valid=1 and ptr=4.
  - Required: next cycle gnt=0, gnt_valid=0, ptr=RESET_PTR; the handshake's pointer update is discarded.
